// File: rtl/fifo_to_nvme_reader.sv
// Drain engine for the single-entry NVMe CDC FIFO: pops one wide entry, checks its header,
// and streams its payload out as BEAT_WIDTH beats on a valid/ready interface.
module fifo_to_nvme_reader #(
  parameter int unsigned DATA_WIDTH = 771,
  parameter int unsigned BEAT_WIDTH = 256,
  parameter int unsigned MAX_BEATS  = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  aclr,
  input  logic                  rdempty,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  rdreq,
  output logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic                  beat_last,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  entry_count,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [1:0]            idx_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic [1:0] q_nm1;
  logic [1:0] hold_nm1;
  logic       hold_last;
  logic       at_last_beat;

  assign q_nm1        = q[DATA_WIDTH-2:DATA_WIDTH-3];
  assign hold_nm1     = hold_q[DATA_WIDTH-2:DATA_WIDTH-3];
  assign hold_last    = hold_q[DATA_WIDTH-1];
  assign at_last_beat = (idx_q == hold_nm1);

  always_comb begin
    state_d    = state_q;
    rdreq      = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by aclr so the pop request is also forced low while in reset.
        rdreq = !rdempty && !aclr;
        if (!rdempty) state_d = StLoad;
      end
      StLoad: begin
        state_d = (q_nm1 == 2'b11) ? StIdle : StSend;
      end
      StSend: begin
        beat_valid = 1'b1;
        beat_last  = at_last_beat && hold_last;
        if (beat_ready && at_last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (idx_q == 2'(i)) beat_data = hold_q[i*BEAT_WIDTH +: BEAT_WIDTH];
    end
  end

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      state_q <= StIdle;
      hold_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == StLoad) && (q_nm1 == 2'b11);
      if (state_q == StLoad) begin
        hold_q <= q;
        idx_q  <= '0;
      end else if (state_q == StSend && beat_ready) begin
        if (at_last_beat) count_q <= count_q + CNT_WIDTH'(1);
        else              idx_q   <= idx_q + 2'd1;
      end
    end
  end

  assign err_pulse   = err_q;
  assign entry_count = count_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_to_nvme_reader.sv
// Randomized self-checking bench: a queue-based FIFO model feeds the reader and a
// scoreboard derived from the entry format checks every beat, error pulse and count.
module tb_fifo_to_nvme_reader;
  localparam int DW = 771;
  localparam int BW = 256;
  localparam int CW = 4;

  logic          rdclk = 1'b0;
  logic          aclr;
  logic          rdempty;
  logic [DW-1:0] q = '0;
  logic          rdreq;
  logic [BW-1:0] beat_data;
  logic          beat_valid;
  logic          beat_ready;
  logic          beat_last;
  logic          err_pulse;
  logic [CW-1:0] entry_count;
  logic          busy;

  fifo_to_nvme_reader #(.CNT_WIDTH(CW)) dut (
    .rdclk(rdclk), .aclr(aclr), .rdempty(rdempty), .q(q), .rdreq(rdreq),
    .beat_data(beat_data), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_last(beat_last), .err_pulse(err_pulse), .entry_count(entry_count), .busy(busy)
  );

  always #5 rdclk = ~rdclk;

  // FIFO model: write side driven by the tests, read side by rdreq.
  logic [DW-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rdempty = (wr_ptr == rd_ptr);

  always @(posedge rdclk) begin
    if (rdreq && !rdempty) begin
      q      <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor
  int            cyc = 0;
  logic [BW:0]   hs_q[$];
  int            hs_cyc[$];
  int            err_cyc[$];
  int            rdreq_cyc[$];
  int            bad_rdreq = 0;

  always @(posedge rdclk) cyc <= cyc + 1;

  always @(negedge rdclk) begin
    if (beat_valid && beat_ready) begin
      hs_q.push_back({beat_last, beat_data});
      hs_cyc.push_back(cyc);
    end
    if (err_pulse) err_cyc.push_back(cyc);
    if (rdreq) rdreq_cyc.push_back(cyc);
    if (rdreq && (rdempty || busy)) bad_rdreq++;
  end

  // Reference model
  logic [BW:0] exp_hs[$];
  int exp_err   = 0;
  int exp_count = 0;
  int n_cmp     = 0;
  int n_fail    = 0;

  function automatic logic [DW-1:0] mk(input bit last, input logic [1:0] nm1);
    logic [DW-1:0] e;
    e = '0;
    for (int i = 0; i < 3 * BW / 32; i++) e[i*32 +: 32] = $urandom;
    e[DW-1]      = last;
    e[DW-2 -: 2] = nm1;
    return e;
  endfunction

  task automatic push(input logic [DW-1:0] e);
    int nm1;
    mem[wr_ptr % 64] = e;
    wr_ptr++;
    nm1 = int'(e[DW-2 -: 2]);
    if (nm1 == 3) exp_err++;
    else begin
      for (int i = 0; i <= nm1; i++)
        exp_hs.push_back({(i == nm1) && e[DW-1], e[i*BW +: BW]});
      exp_count = (exp_count + 1) % (1 << CW);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #2;
  endtask

  task automatic wait_idle(input bit rnd, output bit to);
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (rnd) beat_ready = 1'($urandom_range(0, 1));
      if (rd_ptr == wr_ptr && !busy) begin
        to = 1'b0;
        break;
      end
    end
    tick();
    tick();
    beat_ready = 1'b1;
  endtask

  task automatic test_reset();
    bit to;
    aclr       = 1'b1;
    beat_ready = 1'b1;
    push(mk(1'b1, 2'd0));
    tick();
    tick();
    n_cmp += 5;
    if (rdreq !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq got %b want 0", rdreq); end
    if (beat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", beat_valid); end
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_pulse); end
    if (entry_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", entry_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    aclr = 1'b0;
    wait_idle(1'b0, to);
    n_cmp += 3;
    if (to) begin n_fail++; $display("FAIL reset_drain timeout"); end
    if (hs_q.size() != 1 || hs_q[0] !== exp_hs[0]) begin
      n_fail++; $display("FAIL reset_first_beat got %0d beats want 1 matching", hs_q.size());
    end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL reset_first_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_three_beat();
    bit to;
    int h0 = hs_q.size();
    int r0 = rdreq_cyc.size();
    push(mk(1'b1, 2'd2));
    wait_idle(1'b0, to);
    n_cmp += 4;
    if (to) begin n_fail++; $display("FAIL three_beat timeout"); end
    if (rdreq_cyc.size() != r0 + 1) begin
      n_fail++; $display("FAIL three_rdreq got %0d want 1", rdreq_cyc.size() - r0);
    end
    if (hs_q.size() != h0 + 3) begin
      n_fail++; $display("FAIL three_beats got %0d want 3", hs_q.size() - h0);
    end else if (rdreq_cyc.size() > r0) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp += 2;
        if (hs_cyc[h0+k] != rdreq_cyc[r0] + 2 + k) begin
          n_fail++;
          $display("FAIL three_timing beat %0d got +%0d want +%0d", k,
                   hs_cyc[h0+k] - rdreq_cyc[r0], 2 + k);
        end
        if (hs_q[h0+k] !== exp_hs[h0+k]) begin
          n_fail++;
          $display("FAIL three_data beat %0d got last=%b want last=%b", k,
                   hs_q[h0+k][BW], exp_hs[h0+k][BW]);
        end
      end
    end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL three_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad = 0;
    int h0 = hs_q.size();
    int r0 = rdreq_cyc.size();
    beat_ready = 1'b0;
    push(mk(1'b0, 2'd1));
    to = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (beat_valid) begin to = 1'b0; break; end
    end
    n_cmp += 2;
    if (to) begin n_fail++; $display("FAIL bp_valid timeout"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge rdclk);
      if (!beat_valid || beat_data !== exp_hs[h0][BW-1:0] || beat_last !== exp_hs[h0][BW]) bad++;
    end
    if (bad != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
    tick();
    beat_ready = 1'b1;
    wait_idle(1'b0, to);
    n_cmp += 5;
    if (to) begin n_fail++; $display("FAIL bp_drain timeout"); end
    if (rdreq_cyc.size() != r0 + 1) begin
      n_fail++; $display("FAIL bp_rdreq got %0d want 1", rdreq_cyc.size() - r0);
    end
    if (hs_q.size() != h0 + 2) begin
      n_fail++; $display("FAIL bp_beats got %0d want 2", hs_q.size() - h0);
    end else begin
      if (hs_q[h0] !== exp_hs[h0]) begin n_fail++; $display("FAIL bp_beat0 data differs"); end
      if (hs_q[h0+1] !== exp_hs[h0+1]) begin n_fail++; $display("FAIL bp_beat1 data differs"); end
    end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL bp_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_malformed();
    bit to;
    int h0 = hs_q.size();
    int r0 = rdreq_cyc.size();
    int e0 = err_cyc.size();
    push(mk(1'($urandom_range(0, 1)), 2'd3));
    wait_idle(1'b0, to);
    n_cmp += 4;
    if (to) begin n_fail++; $display("FAIL bad_timeout"); end
    if (err_cyc.size() != e0 + 1 || rdreq_cyc.size() != r0 + 1) begin
      n_fail++; $display("FAIL bad_err pulses got %0d want 1", err_cyc.size() - e0);
    end else if (err_cyc[e0] != rdreq_cyc[r0] + 2) begin
      n_fail++; $display("FAIL bad_err_timing got +%0d want +2", err_cyc[e0] - rdreq_cyc[r0]);
    end
    if (hs_q.size() != h0) begin n_fail++; $display("FAIL bad_beats got %0d want 0", hs_q.size() - h0); end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL bad_count got %0d want %0d", entry_count, exp_count);
    end
    push(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))));
    wait_idle(1'b0, to);
    n_cmp += 2;
    if (hs_q.size() != exp_hs.size()) begin
      n_fail++; $display("FAIL bad_next beats got %0d want %0d", hs_q.size(), exp_hs.size());
    end else begin
      for (int i = h0; i < hs_q.size(); i++) begin
        n_cmp++;
        if (hs_q[i] !== exp_hs[i]) begin n_fail++; $display("FAIL bad_next_data beat %0d", i - h0); end
      end
    end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL bad_next_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int h0 = hs_q.size();
    push(mk(1'($urandom_range(0, 1)), 2'd0));
    push(mk(1'($urandom_range(0, 1)), 2'd0));
    wait_idle(1'b0, to);
    n_cmp += 3;
    if (to) begin n_fail++; $display("FAIL b2b_timeout"); end
    if (hs_q.size() != h0 + 2) begin
      n_fail++; $display("FAIL b2b_beats got %0d want 2", hs_q.size() - h0);
    end else begin
      n_cmp += 3;
      if (hs_cyc[h0+1] - hs_cyc[h0] != 3) begin
        n_fail++; $display("FAIL b2b_gap got %0d want 3", hs_cyc[h0+1] - hs_cyc[h0]);
      end
      if (hs_q[h0] !== exp_hs[h0]) begin n_fail++; $display("FAIL b2b_first data/last differs"); end
      if (hs_q[h0+1] !== exp_hs[h0+1]) begin n_fail++; $display("FAIL b2b_second data/last differs"); end
    end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_random();
    bit to;
    int h0 = hs_q.size();
    int r0 = rdreq_cyc.size();
    int e0 = err_cyc.size();
    int x0 = exp_err;
    int pushed = 0;
    int bad = 0;
    for (int n = 0; n < 24; n++) begin
      push(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))));
      pushed++;
      if ($urandom_range(0, 1) == 1) begin
        push(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))));
        pushed++;
      end
      wait_idle(1'b1, to);
      if (to) bad++;
    end
    n_cmp += 6;
    if (bad != 0) begin n_fail++; $display("FAIL rand_timeout got %0d want 0", bad); end
    if (hs_q.size() != exp_hs.size()) begin
      n_fail++; $display("FAIL rand_beats got %0d want %0d", hs_q.size(), exp_hs.size());
    end else begin
      bad = 0;
      for (int i = h0; i < hs_q.size(); i++) if (hs_q[i] !== exp_hs[i]) bad++;
      if (bad != 0) begin n_fail++; $display("FAIL rand_data got %0d wrong beats want 0", bad); end
    end
    if (err_cyc.size() - e0 != exp_err - x0) begin
      n_fail++; $display("FAIL rand_err got %0d want %0d", err_cyc.size() - e0, exp_err - x0);
    end
    if (rdreq_cyc.size() - r0 != pushed) begin
      n_fail++; $display("FAIL rand_rdreq got %0d want %0d", rdreq_cyc.size() - r0, pushed);
    end
    if (bad_rdreq != 0) begin n_fail++; $display("FAIL rand_illegal_rdreq got %0d want 0", bad_rdreq); end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", entry_count, exp_count);
    end
  endtask

  task automatic test_wrap_abort();
    bit to;
    int r0;
    int h0;
    for (int n = 0; n < 16 && exp_count != (1 << CW) - 1; n++) begin
      push(mk(1'b1, 2'd0));
      wait_idle(1'b0, to);
    end
    n_cmp += 2;
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL wrap_pre got %0d want %0d", entry_count, exp_count);
    end
    push(mk(1'b1, 2'd0));
    wait_idle(1'b0, to);
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL wrap_count got %0d want %0d", entry_count, exp_count);
    end
    beat_ready = 1'b0;
    push(mk(1'b1, 2'd2));
    to = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (beat_valid) begin to = 1'b0; break; end
    end
    n_cmp += 6;
    if (to) begin n_fail++; $display("FAIL abort_valid timeout"); end
    tick();
    r0 = rdreq_cyc.size();
    h0 = hs_q.size();
    aclr = 1'b1;
    exp_count = 0;
    #1;
    if (beat_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", beat_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    if (beat_last !== 1'b0) begin n_fail++; $display("FAIL abort_last got %b want 0", beat_last); end
    if (entry_count !== CW'(exp_count)) begin
      n_fail++; $display("FAIL abort_count got %0d want %0d", entry_count, exp_count);
    end
    if (rdreq !== 1'b0) begin n_fail++; $display("FAIL abort_rdreq got %b want 0", rdreq); end
    tick();
    tick();
    aclr = 1'b0;
    beat_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    n_cmp += 3;
    if (rdreq_cyc.size() != r0) begin
      n_fail++; $display("FAIL abort_refetch got %0d rdreq want 0", rdreq_cyc.size() - r0);
    end
    if (hs_q.size() != h0) begin
      n_fail++; $display("FAIL abort_beats got %0d want 0", hs_q.size() - h0);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got %b want 0", busy); end
  endtask

  initial begin
    aclr       = 1'b1;
    beat_ready = 1'b1;
    test_reset();
    test_three_beat();
    test_backpressure();
    test_malformed();
    test_back_to_back();
    test_random();
    test_wrap_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
